hilo_muldiv_ctrl: RTL and testbench

Execute-stage sequencer for the HI/LO register pair and the multi-cycle multiply/divide datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs an iterative shift-add multiply or restoring divide. While an operation runs it holds the pipeline with a stall. It owns the architectural HI/LO registers and drives the `hi_new`/`lo_new` values that decode forwards from.

---
 rtl/hilo_muldiv_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner and multi-cycle multiply/divide sequencer for the execute stage.
// Optional build macro MULDIV_FAST_MULT_EN selects a single-cycle 32x32 multiplier for MULT/MULTU.
module hilo_muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_new,
  output logic [31:0] lo_new
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] counter;
  logic [1:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   hi_q, lo_q;
  logic [63:0]   acc, mcand;
  logic [31:0]   mplier;
  logic [31:0]   rem, quo, dvsr;
  logic          div_zero, neg_q, neg_r;

  logic          accept, accept_iter, accept_fast;
  logic          in_signed;
  logic [63:0]   ext_a;
  logic [31:0]   mag_a, mag_b;
  logic          last_iter, is_div_q, signed_q, mult_sub;
  logic [63:0]   acc_step;
  logic [32:0]   shifted;
  logic [33:0]   diff;
  logic [31:0]   rem_step, quo_step;
  logic [31:0]   div_hi, div_lo;

  assign hi_new = hi_q;
  assign lo_new = lo_q;

  // Input-side decode: operand extension and magnitudes used when an op is latched.
  always_comb begin
    in_signed = ~op[0];
    ext_a     = in_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    mag_a     = (in_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    mag_b     = (in_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
    accept    = (state == IDLE) && start && !flush;
`ifdef MULDIV_FAST_MULT_EN
    accept_iter = accept && (op == 3'd2 || op == 3'd3);
    accept_fast = accept && (op == 3'd0 || op == 3'd1);
`else
    accept_iter = accept && (op <= 3'd3);
    accept_fast = 1'b0;
`endif
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] ext_b, fast_prod;
  always_comb begin
    ext_b     = in_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    fast_prod = ext_a * ext_b;
  end
`endif

  // One iteration of each datapath; the final iteration's result is what lands in HI/LO.
  always_comb begin
    is_div_q  = op_q[1];
    signed_q  = ~op_q[0];
    last_iter = (state == RUN) && (counter == CW'(ITER - 1));
    // The top multiplier bit carries negative weight in two's complement.
    mult_sub  = signed_q && (counter == CW'(ITER - 1));
    acc_step  = acc;
    if (mplier[0])
      acc_step = mult_sub ? (acc - mcand) : (acc + mcand);

    shifted = {rem, quo[31]};
    diff    = {1'b0, shifted} - {2'b00, dvsr};
    if (diff[33]) begin
      rem_step = shifted[31:0];
      quo_step = {quo[30:0], 1'b0};
    end else begin
      rem_step = diff[31:0];
      quo_step = {quo[30:0], 1'b1};
    end

    div_lo = neg_q ? (32'd0 - quo_step) : quo_step;
    div_hi = neg_r ? (32'd0 - rem_step) : rem_step;
    if (div_zero) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and pipeline handshake outputs.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush && (op <= 3'd3))
          stall = 1'b1;
        if (accept_iter)
          state_next = RUN;
        else if (accept_fast)
          state_next = DONE;
      end
      RUN: begin
        stall = 1'b1;
        if (last_iter)
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  // Datapath and architectural HI/LO; a flush abandons any in-flight op without writing.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      mplier   <= 32'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvsr     <= 32'd0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (flush) begin
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op == 3'd4)
            hi_q <= src_a;
          if (start && op == 3'd5)
            lo_q <= src_a;
          if (accept_iter) begin
            counter  <= '0;
            op_q     <= op[1:0];
            a_q      <= src_a;
            acc      <= 64'd0;
            mcand    <= ext_a;
            mplier   <= src_b;
            rem      <= 32'd0;
            quo      <= mag_a;
            dvsr     <= mag_b;
            div_zero <= (src_b == 32'd0);
            neg_q    <= in_signed && (src_a[31] ^ src_b[31]);
            neg_r    <= in_signed && src_a[31];
          end
`ifdef MULDIV_FAST_MULT_EN
          if (accept_fast) begin
            hi_q <= fast_prod[63:32];
            lo_q <= fast_prod[31:0];
          end
`endif
        end
        RUN: begin
          counter <= counter + CW'(1);
          acc     <= acc_step;
          mcand   <= {mcand[62:0], 1'b0};
          mplier  <= {1'b0, mplier[31:1]};
          rem     <= rem_step;
          quo     <= quo_step;
          if (last_iter) begin
            counter <= '0;
            if (is_div_q) begin
              hi_q <= div_hi;
              lo_q <= div_lo;
            end else begin
              hi_q <= acc_step[63:32];
              lo_q <= acc_step[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus randomized ops against an arithmetic model.
// Honours MULDIV_FAST_MULT_EN for expected multiply latency.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi_new;
  logic [31:0] lo_new;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  hilo_muldiv_ctrl #(.ITER(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .hi_new (hi_new),
    .lo_new (lo_new)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference: returns {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = (o == 3'd2) ? sa / sb : ua / ub;
          r = (o == 3'd2) ? sa % sb : ua % ub;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Issues one iterative op and checks the full stall/done timeline and result.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input bit hold_start);
    int lat;
    int bad;
    lat = (FAST && o <= 3'd1) ? 1 : 33;
    bad = 0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 checkOutput({tag, "_stall_c0"}, 32'(stall), 32'd1);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      #1;
      if (stall !== 1'b1 || done !== 1'b0) bad++;
    end
    checkOutput({tag, "_busy_cycles"}, 32'(bad), 32'd0);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    #1;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_stall_done"}, 32'(stall), 32'd0);
    checkOutput({tag, "_hi"}, hi_new, exp_hi);
    checkOutput({tag, "_lo"}, lo_new, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  task automatic apply_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a;
    #1 checkOutput({tag, "_nostall"}, 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) model_hi = a;
    else model_lo = a;
    #1;
    checkOutput({tag, "_hi"}, hi_new, model_hi);
    checkOutput({tag, "_lo"}, lo_new, model_lo);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    checkOutput({tag, "_no_done"}, 32'(pulses), 32'd0);
    checkOutput({tag, "_hi_kept"}, hi_new, model_hi);
    checkOutput({tag, "_lo_kept"}, lo_new, model_lo);
  endtask

  initial begin
    logic [63:0] r;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_hi", hi_new, 32'd0);
    checkOutput("rst_lo", lo_new, 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    applyStimulus("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    applyStimulus("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("div_5_0", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("divu_9_0", 3'd3, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    applyStimulus("mult_m1_2", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("multu_m1_2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);

    apply_mt("mtlo", 3'd5, 32'h0000_ABCD);
    apply_mt("mthi", 3'd4, 32'h5555_0001);

    // MTHI colliding with a flush must not write HI.
    @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'h0000_1234; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 checkOutput("mthi_flush_hi", hi_new, model_hi);

    // Flush of a divide in cycle 10.
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 checkOutput("flush_stall", 32'(stall), 32'd0);
    quiet_window("flush", 40);

    // Unused ops 6/7 do nothing.
    @(negedge clk);
    start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF;
    #1 checkOutput("op6_stall", 32'(stall), 32'd0);
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    quiet_window("op67", 3);

    // start held through DONE: one op, one pulse.
    applyStimulus("hold_mult", 3'd0, 32'd12345, 32'hFFFF_FFF0,
                  32'hFFFF_FFFF, 32'hFFFC_FC70, 1'b1);
    quiet_window("hold", 40);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (ro >= 3'd4) begin
        apply_mt($sformatf("rnd%0d_mt", i), ro, ra);
      end else begin
        r = ref_result(ro, ra, rb);
        applyStimulus($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, r[63:32], r[31:0], 1'b0);
      end
    end

    // Reset in the middle of an operation clears HI/LO.
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd77; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1;
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    quiet_window("midrst", 40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
